// File: rtl/irq_timer.sv
// Memory-mapped 16-bit interval timer with prescaler, tear-free counter reads
// and a level interrupt request, attached to an 8-bit bidirectional data bus.
module irq_timer #(
    parameter logic [15:0] BASE     = 16'hD000,
    parameter int          PRESCALE = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] abh,
    input  logic [7:0] abl,
    input  logic       rw,
    inout  wire  [7:0] dataio,
    output logic       irq
);

    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] latch_q, latch_d;
    logic [15:0] counter_q, counter_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  pre_q, pre_d;
    logic        cont_q, cont_d;
    logic        ie_q, ie_d;
    logic        flag_q, flag_d;
    logic        irq_q, irq_d;

    logic        sel_s, wr_s, rd_s, ctrl_wr_s, load_s, en_s, en_rise_s;
    logic        tick_s, expire_s, status_rd_s;
    logic [1:0]  reg_s;
    logic [7:0]  rdata_s;

    assign sel_s       = ({abh, abl[7:2]} == BASE[15:2]);
    assign reg_s       = abl[1:0];
    assign wr_s        = sel_s & ~rw;
    assign rd_s        = sel_s & rw;
    assign ctrl_wr_s   = wr_s & (reg_s == 2'd2);
    assign status_rd_s = rd_s & (reg_s == 2'd3);
    assign load_s      = ctrl_wr_s & dataio[7];
    assign en_s        = (state_q == RUN);
    assign en_rise_s   = ctrl_wr_s & dataio[0] & ~en_s;
    assign tick_s      = en_s & (pre_q == 8'd0);
    // LOAD in the same cycle suppresses the expiry entirely
    assign expire_s    = tick_s & (counter_q == 16'd0) & ~load_s;

    assign dataio = rd_s ? rdata_s : 8'hzz;
    assign irq    = irq_q;

    // Next-state and read-data logic for every register
    always_comb begin
        case (reg_s)
            2'd0:    rdata_s = counter_q[7:0];
            2'd1:    rdata_s = hold_q;
            2'd2:    rdata_s = {5'b00000, ie_q, cont_q, en_s};
            2'd3:    rdata_s = {flag_q, 6'b000000, en_s};
            default: rdata_s = 8'h00;
        endcase

        if (wr_s && (reg_s == 2'd0)) begin
            latch_d = {latch_q[15:8], dataio};
        end else if (wr_s && (reg_s == 2'd1)) begin
            latch_d = {dataio, latch_q[7:0]};
        end else begin
            latch_d = latch_q;
        end

        if (ctrl_wr_s) begin
            cont_d = dataio[1];
            ie_d   = dataio[2];
        end else begin
            cont_d = cont_q;
            ie_d   = ie_q;
        end

        // Snapshot the high byte as it was before any tick on this edge
        if (rd_s && (reg_s == 2'd0)) begin
            hold_d = counter_q[15:8];
        end else begin
            hold_d = hold_q;
        end

        if (load_s || en_rise_s || tick_s) begin
            pre_d = PRE_MAX;
        end else if (en_s) begin
            pre_d = pre_q - 8'd1;
        end else begin
            pre_d = pre_q;
        end

        if (load_s) begin
            counter_d = latch_q;
        end else if (tick_s && (counter_q != 16'd0)) begin
            counter_d = counter_q - 16'd1;
        end else if (expire_s && cont_q) begin
            counter_d = latch_q;
        end else begin
            counter_d = counter_q;
        end

        if (expire_s) begin
            flag_d = 1'b1;
        end else if (status_rd_s) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end

        if (ctrl_wr_s) begin
            state_d = dataio[0] ? RUN : IDLE;
        end else if (expire_s && !cont_q) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end

        irq_d = flag_q & ie_q;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            latch_q   <= 16'hFFFF;
            counter_q <= 16'hFFFF;
            hold_q    <= 8'h00;
            pre_q     <= PRE_MAX;
            cont_q    <= 1'b0;
            ie_q      <= 1'b0;
            flag_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            latch_q   <= latch_d;
            counter_q <= counter_d;
            hold_q    <= hold_d;
            pre_q     <= pre_d;
            cont_q    <= cont_d;
            ie_q      <= ie_d;
            flag_q    <= flag_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_irq_timer.sv
// Scoreboard bench for irq_timer: two instances (PRESCALE 1 at D000, PRESCALE 4
// at E000) share one bus; stimulus queues expectations, a monitor checks them.
module tb_irq_timer;

    logic       clk;
    logic       clr;
    logic [7:0] abh;
    logic [7:0] abl;
    logic       rw;
    logic       irq_a;
    logic       irq_b;
    logic       tb_oe;
    logic [7:0] tb_drv;
    logic       chk_en;
    wire  [7:0] dataio;

    assign dataio = tb_oe ? tb_drv : 8'hzz;

    irq_timer #(.BASE(16'hD000), .PRESCALE(1)) u_dut_a (
        .clk(clk), .clr(clr), .abh(abh), .abl(abl), .rw(rw),
        .dataio(dataio), .irq(irq_a)
    );

    irq_timer #(.BASE(16'hE000), .PRESCALE(4)) u_dut_b (
        .clk(clk), .clr(clr), .abh(abh), .abl(abl), .rw(rw),
        .dataio(dataio), .irq(irq_b)
    );

    typedef struct {
        string      nm;
        int         src;
        logic [7:0] val;
    } item_t;

    item_t sb[$];
    int    n_tests;
    int    n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive at the falling edge, DUT samples at the next rising edge
    task automatic bus_cycle(input logic [15:0] addr, input logic rw_i, input logic oe_i,
                             input logic [7:0] d, input logic chk, input string nm,
                             input int src, input logic [7:0] exp_v);
        item_t it;
        @(negedge clk);
        abh    = addr[15:8];
        abl    = addr[7:0];
        rw     = rw_i;
        tb_oe  = oe_i;
        tb_drv = d;
        chk_en = chk;
        if (chk) begin
            it.nm  = nm;
            it.src = src;
            it.val = exp_v;
            sb.push_back(it);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] d);
        bus_cycle(addr, 1'b0, 1'b1, d, 1'b0, "", 0, 8'h00);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] exp_v, input string nm);
        bus_cycle(addr, 1'b1, 1'b0, 8'h00, 1'b1, nm, 0, exp_v);
    endtask

    task automatic rd_drv(input logic [15:0] addr, input logic [7:0] d, input string nm);
        bus_cycle(addr, 1'b1, 1'b1, d, 1'b1, nm, 0, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, "", 0, 8'h00);
    endtask

    task automatic chk_irq(input int src, input logic exp_v, input string nm);
        bus_cycle(16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, nm, src, {7'b0000000, exp_v});
    endtask

    // Monitor: whenever a checked cycle is presented, pop and compare
    initial begin
        item_t      it;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got no expectation, required one");
                end else begin
                    it = sb.pop_front();
                    case (it.src)
                        0:       act = dataio;
                        1:       act = {7'b0000000, irq_a};
                        default: act = {7'b0000000, irq_b};
                    endcase
                    if (act !== it.val) begin
                        n_fail++;
                        $display("FAIL %s: got %02h required %02h", it.nm, act, it.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr     = 1'b0;
        abh     = 8'h00;
        abl     = 8'h00;
        rw      = 1'b1;
        tb_oe   = 1'b0;
        tb_drv  = 8'h00;
        chk_en  = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;

        // Reset values
        rd(16'hD001, 8'h00, "rst_hold");
        rd(16'hD000, 8'hFF, "rst_cnt_lo");
        rd(16'hD001, 8'hFF, "rst_cnt_hi");
        rd(16'hD002, 8'h00, "rst_ctrl");
        rd(16'hD003, 8'h00, "rst_status");
        chk_irq(1, 1'b0, "rst_irq");

        // One-shot, latch 3, PRESCALE 1: irq rises 5 clocks after the CTRL edge
        wr(16'hD000, 8'h03);
        wr(16'hD001, 8'h00);
        wr(16'hD002, 8'h85);
        idle(4);
        chk_irq(1, 1'b0, "os_irq_early");
        chk_irq(1, 1'b1, "os_irq_rise");
        rd(16'hD003, 8'h80, "os_status1");
        chk_irq(1, 1'b1, "os_irq_hold");
        chk_irq(1, 1'b0, "os_irq_fall");
        rd(16'hD003, 8'h00, "os_status2");
        rd(16'hD000, 8'h00, "os_cnt_zero");
        rd(16'hD002, 8'h04, "os_ctrl");

        // Continuous, latch 1, PRESCALE 4: expiry every 8 clocks
        wr(16'hE000, 8'h01);
        wr(16'hE001, 8'h00);
        wr(16'hE002, 8'h87);
        idle(7);
        chk_irq(2, 1'b0, "cont_irq_early");
        rd(16'hE003, 8'h81, "cont_status1");
        chk_irq(2, 1'b1, "cont_irq_rise");
        chk_irq(2, 1'b0, "cont_irq_fall");
        idle(4);
        rd(16'hE003, 8'h01, "collide_rd_on_expiry");
        rd(16'hE003, 8'h81, "collide_flag_kept");
        chk_irq(2, 1'b1, "cont_irq_rise2");
        idle(6);
        rd(16'hE003, 8'h81, "cont_status3");
        wr(16'hE002, 8'h00);

        // Tear-free read with a tick on the CNT_LO read cycle
        wr(16'hD000, 8'h00);
        wr(16'hD001, 8'h01);
        wr(16'hD002, 8'h81);
        rd(16'hD000, 8'h00, "tear_lo");
        rd(16'hD001, 8'h01, "tear_hi");
        rd(16'hD000, 8'hFE, "tear_next");

        // LOAD on a tick cycle: counter takes latch, no decrement
        wr(16'hD002, 8'h81);
        rd(16'hD000, 8'h00, "load_tick_lo");
        rd(16'hD001, 8'h01, "load_tick_hi");
        wr(16'hD002, 8'h00);

        // latch 0 continuous: flag on every tick, counter never below 0
        wr(16'hD000, 8'h00);
        wr(16'hD001, 8'h00);
        wr(16'hD002, 8'h83);
        rd(16'hD003, 8'h01, "wrap_first");
        rd(16'hD003, 8'h81, "wrap_flag");
        rd(16'hD000, 8'h00, "wrap_cnt");
        rd(16'hD003, 8'h81, "wrap_flag_again");
        wr(16'hD002, 8'h00);
        rd(16'hD003, 8'h80, "ctrl_off_on_expiry");
        rd(16'hD003, 8'h00, "ctrl_off_cleared");

        // Decode boundaries and bus release
        wr(16'hCFFF, 8'h55);
        wr(16'hD004, 8'h55);
        rd_drv(16'hCFFF, 8'hA5, "release_below");
        rd_drv(16'hD004, 8'hA5, "release_above");
        wr(16'hD002, 8'h80);
        rd(16'hD000, 8'h00, "decode_latch_lo");
        rd(16'hD001, 8'h00, "decode_latch_hi");
        rd(16'hD002, 8'h00, "decode_ctrl");

        // Reset in the middle of activity
        wr(16'hE000, 8'h10);
        wr(16'hE001, 8'h00);
        wr(16'hE002, 8'h87);
        wr(16'hD000, 8'h00);
        wr(16'hD001, 8'h00);
        wr(16'hD002, 8'h85);
        idle(2);
        chk_irq(1, 1'b1, "pre_rst_irq");
        idle(1);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        chk_irq(1, 1'b0, "midrst_irq_a");
        chk_irq(2, 1'b0, "midrst_irq_b");
        rd(16'hD000, 8'hFF, "midrst_a_lo");
        rd(16'hD001, 8'hFF, "midrst_a_hi");
        rd(16'hD002, 8'h00, "midrst_a_ctrl");
        rd(16'hD003, 8'h00, "midrst_a_status");
        rd(16'hE000, 8'hFF, "midrst_b_lo");
        rd(16'hE002, 8'h00, "midrst_b_ctrl");
        rd(16'hE003, 8'h00, "midrst_b_status");

        idle(2);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_timer.md
# irq_timer

Memory-mapped 16-bit interval timer sitting on the processor bus downstream of the CPU board, in parallel with `ram`. It decodes the `abh`/`abl` address bus and the `rw` strobe, and exposes four byte registers on `dataio`. It drives the level `irq` input of the CPU board when the count expires and interrupts are enabled.

## Interface
- `BASE`, default `16'hD000`: base address of the 4-byte register window. Bits [1:0] must be 0.
- `PRESCALE`, default `1`: number of `clk` cycles per counter tick. Legal range 1..256.
- `clk` input 1: system clock. All state is updated on the rising edge.
- `clr` input 1: asynchronous, active-low reset.
- `abh` input 8: address bus, high byte.
- `abl` input 8: address bus, low byte.
- `rw` input 1: bus direction. 1 = CPU read, 0 = CPU write.
- `dataio` inout 8: data bus. Driven only during a selected read, otherwise `8'hzz`.
- `irq` output 1: active-high interrupt request, `flag & IE`.

## Operation
- **Select.** `sel = ({abh,abl}[15:2] == BASE[15:2])`. Register index `r = abl[1:0]`.
- **r=0, CNT_LO.**
  - Write: `latch[7:0]`.
  - Read: `counter[7:0]`. The same read also snapshots `counter[15:8]` into `hold`.
- **r=1, CNT_HI.**
  - Write: `latch[15:8]`.
  - Read: `hold`. This prevents torn 16-bit reads.
- **r=2, CTRL.**
  - bit0 `EN`.
  - bit1 `CONT`: 1 = reload and continue on expiry, 0 = one-shot.
  - bit2 `IE`: interrupt enable.
  - bit7 `LOAD`: write-only strobe, self-clearing, always reads 0.
  - Bits 6:3 read 0 and writes to them are ignored.
- **r=3, STATUS.**
  - Read: bit7 = `flag`, bit0 = `EN`, other bits 0.
  - Side effect: a read clears `flag`.
  - Writes are ignored.
- **Prescaler.**
  - `pre` counts down from `PRESCALE-1` while `EN=1`.
  - `tick` is asserted in the cycle where `EN & (pre==0)`. On that cycle `pre` reloads to `PRESCALE-1`.
  - With `EN=0`, `pre` holds.
- **Counter, on tick.**
  - If `counter != 0`: `counter <= counter - 1`.
  - If `counter == 0`: `flag <= 1`. Then, if `CONT=1`, `counter <= latch`; otherwise `counter` stays 0 and `EN <= 0`.
  - The period is therefore `(latch+1)*PRESCALE` clocks.
- **LOAD strobe.** Writing CTRL with bit7=1 sets `counter <= latch` and `pre <= PRESCALE-1`. The other CTRL bits are written in the same cycle.
- **EN edge.** A CTRL write that takes `EN` from 0 to 1 sets `pre <= PRESCALE-1`.
- **State machine.** Two states, derived from `EN`:
  - IDLE (`EN=0`) goes to RUN on a CTRL write with `EN=1`.
  - RUN goes to IDLE on a CTRL write with `EN=0`, or on one-shot expiry.
  - RUN stays in RUN on a continuous-mode expiry.

## Timing
- **Reset** (`clr=0`, immediate):
  - `latch=16'hFFFF`, `counter=16'hFFFF`, `hold=8'h00`.
  - `EN=CONT=IE=0`, `flag=0`, `pre=PRESCALE-1`.
  - `irq=0`, `dataio=8'hzz`.
  - Reset asserted in the middle of a count aborts it with no flag.
- **Writes.** Sampled on the rising `clk` edge where `sel & ~rw`. New values are visible in the next cycle.
- **Reads.** `dataio` is driven combinationally while `sel & rw`. Read side effects (the `hold` snapshot and the `flag` clear) occur on the rising edge where `sel & rw` holds.
- **irq.** Registered. It rises 1 cycle after the expiry tick when `IE=1`, and falls 1 cycle after a STATUS read or a write with `IE=0`.
- **Simultaneous events.**
  - Expiry tick and STATUS read in the same cycle: set wins, `flag` stays 1.
  - LOAD and tick in the same cycle: LOAD wins, no decrement and no flag.
  - CTRL write with `EN=0` on an expiry tick: `flag` is still set and `EN` ends at 0.
- **Wrap-around.**
  - `latch=0` with `CONT=1`: `flag` sets on every tick.
  - The counter never decrements below 0.
- **Hold snapshot.** A CNT_LO read in the same cycle as a tick snapshots the pre-tick `counter[15:8]`.

## Test plan
- **Reset values.** Drive `clr=0`, then read all four registers → CNT_LO=`FF`, CNT_HI=`FF` (from `hold` after the CNT_LO read), CTRL=`00`, STATUS=`00`, `irq=0`.
- **One-shot.** With PRESCALE=1, write latch=`0x0003`, then CTRL=`0x85` → `irq` rises exactly 5 clocks after the CTRL write edge, and STATUS reads `80` (EN already cleared). A second STATUS read returns `00` and `irq` falls 1 cycle after the first read.
- **Continuous.** With latch=`0x0001`, CTRL=`0x87`, PRESCALE=4 → `flag` sets every 8 clocks. Clear it with a STATUS read each period → `irq` pulses periodically and `EN` stays 1.
- **Tear-free read.** With counter at `0x0100` and a tick due in the same cycle as the CNT_LO read → CNT_LO reads `00` and the following CNT_HI read returns `01`, not `00`.
- **Collisions.** Force a STATUS read on the expiry cycle → `flag` remains 1. Issue LOAD on a tick cycle → `counter==latch` with no decrement.
- **Decode and bus release.** Access `BASE+4` and `BASE-1` → no register changes and `dataio` stays `zz`. Assert `clr` low mid-count → `irq=0` and all registers return to their reset values.
